// File: rtl/vector_mem_responder.sv
// -----------------------------------------------------------------------------
// vector_mem_responder
//
// Purpose:
//   Lane-serial vector memory responder. It accepts one vector load or store
//   while idle, then walks the vector one lane per cycle against an internal
//   lane-wide storage array, and finally holds a response until the processor
//   takes it. Storage contents are never reset.
//
// Parameters:
//   registerSize : lane width in bits
//   vectorSize   : lanes per vector access
//   memDepth     : storage depth in lanes (power of two)
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request can be accepted (IDLE only)
//   req_write  in   1 = vector store, 0 = vector load
//   req_addr   in   lane-granular base address (16 bits)
//   req_wdata  in   store data, lane 0 in the least significant lane
//   resp_valid out  response available (RESP state)
//   resp_ready in   processor accepts response
//   resp_rdata out  load data (all zeros for stores)
//   resp_err   out  out-of-range access flag
//   busy       out  inverse of req_ready
//
// Build option:
//   VMEM_BOUNDS_CHECK_EN  when defined, lanes whose address reaches memDepth
//                         are suppressed (stores) or read as zero (loads) and
//                         resp_err reports it. When undefined, lane addresses
//                         wrap modulo memDepth and resp_err is tied low.
// -----------------------------------------------------------------------------
module vector_mem_responder #(
    parameter int registerSize = 8,
    parameter int vectorSize   = 4,
    parameter int memDepth     = 256
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic                                 req_write,
    input  logic [15:0]                          req_addr,
    input  logic [vectorSize*registerSize-1:0]   req_wdata,
    output logic                                 resp_valid,
    input  logic                                 resp_ready,
    output logic [vectorSize*registerSize-1:0]   resp_rdata,
    output logic                                 resp_err,
    output logic                                 busy
);

    localparam int VW = vectorSize * registerSize;
    localparam int AW = (memDepth > 1) ? $clog2(memDepth) : 1;
    localparam int LW = (vectorSize > 1) ? $clog2(vectorSize) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [LW-1:0]           lane_q, lane_d;
    logic                    write_q, write_d;
    logic [15:0]             addr_q, addr_d;
    logic [VW-1:0]           wdata_q, wdata_d;
    logic [VW-1:0]           rdata_q, rdata_d;

    logic [registerSize-1:0] mem [memDepth];

    // Full-width lane address (one extra bit) so the range check sees carries.
    logic [16:0]             lane_addr;
    logic [AW-1:0]           idx;
    logic                    lane_ok;
    logic                    mem_we;
    logic [registerSize-1:0] lane_wdata;

    assign lane_addr  = {1'b0, addr_q} + {{(17-LW){1'b0}}, lane_q};
    assign idx        = lane_addr[AW-1:0];
    assign lane_wdata = wdata_q[lane_q*registerSize +: registerSize];

`ifdef VMEM_BOUNDS_CHECK_EN
    logic err_q, err_d;

    assign lane_ok = (lane_addr < 17'(memDepth));
`else
    // Wrap-around addressing: bits above the index are intentionally dropped.
    logic unused_lane_addr_hi;

    assign unused_lane_addr_hi = ^lane_addr[16:AW];
    assign lane_ok             = 1'b1;
`endif

    assign mem_we = (state_q == ACCESS) && write_q && lane_ok;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef VMEM_BOUNDS_CHECK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    lane_d  = '0;
                    rdata_d = '0;
`ifdef VMEM_BOUNDS_CHECK_EN
                    err_d   = 1'b0;
`endif
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!write_q) begin
                    rdata_d[lane_q*registerSize +: registerSize] =
                        lane_ok ? mem[idx] : '0;
                end
`ifdef VMEM_BOUNDS_CHECK_EN
                if (!lane_ok) begin
                    err_d = 1'b1;
                end
`endif
                if (lane_q == LW'(vectorSize - 1)) begin
                    lane_d  = '0;
                    state_d = RESP;
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lane_q  <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef VMEM_BOUNDS_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef VMEM_BOUNDS_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Storage is deliberately outside the reset domain; lanes written before
    // a reset survive it. Reset forces IDLE, which blocks further writes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= lane_wdata;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = ~req_ready;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_valid ? rdata_q : '0;

`ifdef VMEM_BOUNDS_CHECK_EN
    assign resp_err = resp_valid & err_q;
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: doc/vector_mem_responder.md
VECTOR_MEM_RESPONDER -- requirements
Module: vector_mem_responder

Interface
REQ-001 Parameter registerSize, default 8, lane width in bits.
REQ-002 Parameter vectorSize, default 4, lanes per vector access.
REQ-003 Parameter memDepth, default 256, storage depth in lanes; SHALL be a power of two.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  1  processor presents a memory request.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_write  input  1  1 = vector store, 0 = vector load.
REQ-009 req_addr  input  16  lane-granular base address.
REQ-010 req_wdata  input  vectorSize x registerSize (packed)  store data, lane 0 in the least significant lane.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  processor accepts the response.
REQ-013 resp_rdata  output  vectorSize x registerSize (packed)  load data.
REQ-014 resp_err  output  1  out-of-range access flag.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; busy SHALL equal the inverse of req_ready.
REQ-018 In IDLE, req_valid=1 SHALL latch req_write, req_addr and req_wdata, clear the lane counter to 0, and enter ACCESS on the next edge.
REQ-019 In ACCESS, one lane per cycle: lane i SHALL use index (addr+i); a store writes wdata[i] to the index; a load captures the stored value at the index into rdata[i].
REQ-020 ACCESS SHALL last exactly vectorSize cycles, then enter RESP.
REQ-021 In RESP, resp_valid=1 and resp_rdata/resp_err SHALL be held stable until the cycle resp_ready=1, then enter IDLE.
REQ-022 Latency: a request accepted at edge T SHALL raise resp_valid after edge T+vectorSize; with resp_ready held 1, req_ready SHALL return after edge T+vectorSize+1.
REQ-023 A request and a response SHALL never complete in the same cycle; requests arriving outside IDLE SHALL be ignored and not queued.
REQ-024 For stores, resp_rdata SHALL be all zeros.
REQ-025 A load that follows a store to the same index SHALL return the stored data.
REQ-026 Inputs req_addr/req_wdata SHALL NOT affect an access in progress; only latched copies are used.

Reset
REQ-027 Asserting rst SHALL immediately force IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, lane counter=0.
REQ-028 Storage contents SHALL NOT be reset; reset during ACCESS SHALL abandon the request, and lanes already stored SHALL remain stored.

Configuration
REQ-029 Macro VMEM_BOUNDS_CHECK_EN compiles in the range check.
REQ-030 Without the macro, lane index SHALL be (addr+i) mod memDepth (wrap-around), and resp_err SHALL be tied to 0.
REQ-031 With the macro, lanes with addr+i >= memDepth (computed without truncation) SHALL suppress the store, or return 0 for a load. resp_err SHALL be 1 in RESP if any lane was out of range. In-range lanes of the same request SHALL complete normally.

Verification
REQ-032 Reset, then store addr=0x10 wdata={0x44,0x33,0x22,0x11} -> resp_valid after 4 cycles, resp_rdata=0; load addr=0x10 -> resp_rdata={0x44,0x33,0x22,0x11}, resp_err=0.
REQ-033 Load issued with resp_ready=0 for 3 cycles -> resp_valid and resp_rdata held for 3 cycles; req_ready stays 0 until the cycle after resp_ready=1.
REQ-034 Store addr=0xFE {0xD4,0xC3,0xB2,0xA1} with no macro -> lanes land at 0xFE,0xFF,0x00,0x01; loads at 0xFE and 0x00 confirm the data. With the macro -> lanes 0xFE,0xFF stored; lanes 2,3 dropped; resp_err=1.
REQ-035 rst asserted in the 2nd ACCESS cycle of a store to 0x20 -> outputs reset at once; a later load of 0x20 returns lane 0 new, lanes 1-3 old.
REQ-036 Toggle req_valid and req_addr during ACCESS -> no extra transactions; the response matches the originally latched request.
